// File: rtl/ct_ifu_bht_pre_array_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_ifu_bht_pre_array_ctrl_if
//   Bundles the BHT predictor array controller's request, response and array
//   signals.
//   slave  : the array controller (ct_ifu_bht_pre_array_ctrl)
//   master : IF lookup / BJU update logic together with the array wrapper
//   Signals:
//     cp0_ifu_bht_inv, bht_inv_busy             invalidate pulse / sweep busy
//     rd_req, rd_index, rd_gnt                  lookup request and grant
//     rd_data_vld, rd_data                      lookup data, one cycle after grant
//     wr_req, wr_index, wr_data, wr_mask, wr_ack   counter update request
//     bht_pre_data_out                          array Q
//     bht_pre_array_clk_en, bht_pred_array_cen_b,
//     bht_pred_array_gwen, bht_pred_array_index,
//     bht_pred_array_din, bht_pred_bwen         array controls
// ---------------------------------------------------------------------------
interface ct_ifu_bht_pre_array_ctrl_if #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 64
);
  logic              cp0_ifu_bht_inv;
  logic              bht_inv_busy;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_index;
  logic              rd_gnt;
  logic              rd_data_vld;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_mask;
  logic              wr_ack;
  logic [DATA_W-1:0] bht_pre_data_out;
  logic              bht_pre_array_clk_en;
  logic              bht_pred_array_cen_b;
  logic              bht_pred_array_gwen;
  logic [IDX_W-1:0]  bht_pred_array_index;
  logic [DATA_W-1:0] bht_pred_array_din;
  logic [DATA_W-1:0] bht_pred_bwen;

  modport slave (
    input  cp0_ifu_bht_inv, rd_req, rd_index, wr_req, wr_index, wr_data, wr_mask,
           bht_pre_data_out,
    output bht_inv_busy, rd_gnt, rd_data_vld, rd_data, wr_ack,
           bht_pre_array_clk_en, bht_pred_array_cen_b, bht_pred_array_gwen,
           bht_pred_array_index, bht_pred_array_din, bht_pred_bwen
  );

  modport master (
    output cp0_ifu_bht_inv, rd_req, rd_index, wr_req, wr_index, wr_data, wr_mask,
           bht_pre_data_out,
    input  bht_inv_busy, rd_gnt, rd_data_vld, rd_data, wr_ack,
           bht_pre_array_clk_en, bht_pred_array_cen_b, bht_pred_array_gwen,
           bht_pred_array_index, bht_pred_array_din, bht_pred_bwen
  );
endinterface

// File: rtl/ct_ifu_bht_pre_array_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ifu_bht_pre_array_ctrl
//   Sequences the single-port BHT predictor array: full-array init sweep,
//   IF-stage lookups and BJU counter updates through a one-entry write buffer.
//   Array controls are combinational from the per-cycle grant; read data is
//   returned the cycle after the grant.
//   Ports:
//     forever_cpuclk  clock (also the array gate-cell clock)
//     cpurst_b        asynchronous active-low reset
//     bus             ct_ifu_bht_pre_array_ctrl_if.slave (requests + array)
//   Optional feature macro:
//     BHT_PRE_CTRL_WR_MERGE_EN  merge an update to the same index into the
//                               pending write buffer instead of stalling it
// ---------------------------------------------------------------------------
module ct_ifu_bht_pre_array_ctrl #(
  parameter int unsigned       IDX_W      = 10,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       STARVE_MAX = 8,
  parameter logic [DATA_W-1:0] INIT_VAL   = {(DATA_W/2){2'b01}}
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  ct_ifu_bht_pre_array_ctrl_if.slave   bus
);

  localparam int unsigned      STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_MAX);
  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e              state_q,    state_d;
  logic                run_q,      run_d;
  logic [IDX_W-1:0]    sweep_q,    sweep_d;
  logic                buf_vld_q,  buf_vld_d;
  logic [IDX_W-1:0]    buf_idx_q,  buf_idx_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [DATA_W-1:0]   buf_mask_q, buf_mask_d;
  logic [STARVE_W-1:0] starve_q,   starve_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [DATA_W-1:0]   din_q,      din_d;
  logic                rd_vld_q,   rd_vld_d;

  logic                rd_gnt_c;
  logic                wr_gnt_c;
  logic                wr_ack_c;
  logic                busy_c;
  logic                cen_b_c;
  logic                gwen_c;
  logic [DATA_W-1:0]   bwen_c;
  logic                buf_free_c;

  // State and datapath registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_INIT;
      run_q      <= 1'b0;
      sweep_q    <= '0;
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
      buf_mask_q <= '0;
      starve_q   <= '0;
      idx_q      <= '0;
      din_q      <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      sweep_q    <= sweep_d;
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      starve_q   <= starve_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // Next state, arbitration and array controls
  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    sweep_d    = sweep_q;
    buf_vld_d  = buf_vld_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    starve_d   = starve_q;
    idx_d      = idx_q;
    din_d      = din_q;
    rd_vld_d   = 1'b0;
    rd_gnt_c   = 1'b0;
    wr_gnt_c   = 1'b0;
    wr_ack_c   = 1'b0;
    busy_c     = 1'b0;
    cen_b_c    = 1'b1;
    gwen_c     = 1'b1;
    bwen_c     = '1;
    buf_free_c = 1'b0;

    case (state_q)
      ST_INIT: begin
        busy_c    = 1'b1;
        buf_vld_d = 1'b0;
        starve_d  = '0;
        // run_q keeps the array quiet on the first edge after reset release
        if (run_q) begin
          cen_b_c = 1'b0;
          gwen_c  = 1'b0;
          bwen_c  = '0;
          idx_d   = sweep_q;
          din_d   = INIT_VAL;
          if (bus.cp0_ifu_bht_inv) begin
            sweep_d = '0;
          end else if (sweep_q == SWEEP_LAST) begin
            sweep_d = '0;
            state_d = ST_IDLE;
          end else begin
            sweep_d = sweep_q + IDX_W'(1);
          end
        end
      end

      ST_IDLE: begin
        // A starved write beats lookups; otherwise lookups win
        if (buf_vld_q && (starve_q >= STARVE_SAT)) begin
          wr_gnt_c = 1'b1;
        end else if (bus.rd_req) begin
          rd_gnt_c = 1'b1;
        end else if (buf_vld_q) begin
          wr_gnt_c = 1'b1;
        end

        if (rd_gnt_c) begin
          cen_b_c = 1'b0;
          idx_d   = bus.rd_index;
        end

        if (wr_gnt_c) begin
          cen_b_c   = 1'b0;
          gwen_c    = 1'b0;
          bwen_c    = ~buf_mask_q;
          idx_d     = buf_idx_q;
          din_d     = buf_data_q;
          buf_vld_d = 1'b0;
          starve_d  = '0;
        end else if (buf_vld_q && (starve_q < STARVE_SAT)) begin
          starve_d = starve_q + STARVE_W'(1);
        end

        rd_vld_d   = rd_gnt_c;
        buf_free_c = !buf_vld_q || wr_gnt_c;

        if (bus.wr_req && buf_free_c) begin
          wr_ack_c   = 1'b1;
          buf_vld_d  = 1'b1;
          buf_idx_d  = bus.wr_index;
          buf_data_d = bus.wr_data;
          buf_mask_d = bus.wr_mask;
        end
`ifdef BHT_PRE_CTRL_WR_MERGE_EN
        // Fold a same-index update into the pending entry; starve age is kept
        else if (bus.wr_req && (bus.wr_index == buf_idx_q)) begin
          wr_ack_c   = 1'b1;
          buf_mask_d = buf_mask_q | bus.wr_mask;
          buf_data_d = (buf_data_q & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
        end
`endif

        // Invalidate: restart the sweep and discard any pending update
        if (bus.cp0_ifu_bht_inv) begin
          state_d   = ST_INIT;
          sweep_d   = '0;
          buf_vld_d = 1'b0;
          starve_d  = '0;
        end
      end

      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Index and din hold their last driven values when the array is idle
  assign bus.bht_pred_array_index = idx_d;
  assign bus.bht_pred_array_din   = din_d;
  assign bus.bht_pred_array_cen_b = cen_b_c;
  assign bus.bht_pred_array_gwen  = gwen_c;
  assign bus.bht_pred_bwen        = bwen_c;
  assign bus.bht_pre_array_clk_en = ~cen_b_c;
  assign bus.bht_inv_busy         = busy_c;
  assign bus.rd_gnt               = rd_gnt_c;
  assign bus.wr_ack               = wr_ack_c;
  assign bus.rd_data_vld          = rd_vld_q;
  assign bus.rd_data              = bus.bht_pre_data_out;

endmodule

// File: tb/tb_ct_ifu_bht_pre_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_bht_pre_array_ctrl
//   Directed bench for the BHT predictor array controller, with a behavioural
//   single-port 1024x64 array behind it. Inputs change and outputs are sampled
//   1 time unit after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ct_ifu_bht_pre_array_ctrl;

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DATA_W = 64;
  localparam logic [63:0] INIT_VAL = 64'h5555_5555_5555_5555;

  logic clk;
  logic rst_n;

  int unsigned n_chk;
  int unsigned n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ct_ifu_bht_pre_array_ctrl_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  ct_ifu_bht_pre_array_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  // Behavioural single-port array: bit write enables active low
  logic [63:0] mem [1024];
  logic [63:0] arr_q;

  initial arr_q = '0;
  always @(posedge clk) begin
    if (!bus.bht_pred_array_cen_b) begin
      if (!bus.bht_pred_array_gwen)
        mem[bus.bht_pred_array_index] <= (mem[bus.bht_pred_array_index] & bus.bht_pred_bwen)
                                       | (bus.bht_pred_array_din & ~bus.bht_pred_bwen);
      else
        arr_q <= mem[bus.bht_pred_array_index];
    end
  end
  assign bus.bht_pre_data_out = arr_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cp0_ifu_bht_inv = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_index = '0;
    bus.wr_req   = 1'b0;
    bus.wr_index = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
  endtask

  // One lookup: grant this cycle, data next cycle
  task automatic do_read(input logic [IDX_W-1:0] idx, input logic [63:0] exp, input string tag);
    tick();
    bus.rd_req = 1'b1; bus.rd_index = idx;
    #1;
    check({tag, "_gnt"}, 64'(bus.rd_gnt), 64'd1);
    check({tag, "_idx"}, 64'(bus.bht_pred_array_index), 64'(idx));
    tick();
    bus.rd_req = 1'b0;
    #1;
    check({tag, "_vld"}, 64'(bus.rd_data_vld), 64'd1);
    check({tag, "_data"}, bus.rd_data, exp);
  endtask

  initial begin
    logic found;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset values
    tick(); #1;
    check("rst_cen_b",  64'(bus.bht_pred_array_cen_b), 64'd1);
    check("rst_gwen",   64'(bus.bht_pred_array_gwen), 64'd1);
    check("rst_bwen",   bus.bht_pred_bwen, '1);
    check("rst_index",  64'(bus.bht_pred_array_index), 64'd0);
    check("rst_din",    bus.bht_pred_array_din, 64'd0);
    check("rst_clk_en", 64'(bus.bht_pre_array_clk_en), 64'd0);
    check("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
    check("rst_rd_vld", 64'(bus.rd_data_vld), 64'd0);
    check("rst_wr_ack", 64'(bus.wr_ack), 64'd0);
    tick();
    rst_n = 1'b1;

    // 1. Init sweep 0..1023, then read idx 5
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      if (!bus.bht_pred_array_cen_b) begin found = 1'b1; break; end
    end
    check("sweep_start", 64'(found), 64'd1);
    for (int i = 0; i < 1024; i++) begin
      if (i != 0) begin tick(); #1; end
      check("sweep_idx", 64'(bus.bht_pred_array_index), 64'(i));
      check("sweep_ctl", {bus.bht_pred_array_cen_b, bus.bht_pred_array_gwen,
                          bus.bht_inv_busy, bus.bht_pre_array_clk_en},
            64'b0011);
      if (bus.bht_pred_bwen !== 64'd0 || bus.bht_pred_array_din !== INIT_VAL)
        check("sweep_data", bus.bht_pred_array_din & ~bus.bht_pred_bwen, INIT_VAL);
    end
    tick(); #1;
    check("sweep_busy_done", 64'(bus.bht_inv_busy), 64'd0);
    check("sweep_idle_cen",  64'(bus.bht_pred_array_cen_b), 64'd1);
    do_read(10'd5, INIT_VAL, "rd5");

    // 2. Masked update of idx 7 while idle
    tick();
    bus.wr_req = 1'b1; bus.wr_index = 10'd7; bus.wr_mask = 64'h3; bus.wr_data = 64'h2;
    #1;
    check("wr7_ack",  64'(bus.wr_ack), 64'd1);
    check("wr7_cen0", 64'(bus.bht_pred_array_cen_b), 64'd1);
    tick();
    bus.wr_req = 1'b0;
    #1;
    check("wr7_gwen",  64'(bus.bht_pred_array_gwen), 64'd0);
    check("wr7_cen",   64'(bus.bht_pred_array_cen_b), 64'd0);
    check("wr7_bwen",  bus.bht_pred_bwen, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wr7_index", 64'(bus.bht_pred_array_index), 64'd7);
    do_read(10'd7, 64'h5555_5555_5555_5556, "rd7");

    // 3. Continuous reads starve a buffered write for 8 grants
    tick();
    bus.rd_req = 1'b1; bus.rd_index = 10'd20;
    bus.wr_req = 1'b1; bus.wr_index = 10'd11; bus.wr_mask = 64'hFF; bus.wr_data = 64'h0;
    #1;
    check("stv_ack",    64'(bus.wr_ack), 64'd1);
    check("stv_rd_gnt", 64'(bus.rd_gnt), 64'd1);
    tick();
    bus.wr_req = 1'b0;
    begin
      int unsigned n_rd;
      n_rd  = 0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (i != 0) tick();
        #1;
        if (!bus.rd_gnt) begin found = 1'b1; break; end
        n_rd++;
      end
      check("stv_forced",  64'(found), 64'd1);
      check("stv_n_reads", 64'(n_rd), 64'd8);
    end
    check("stv_wr_gwen",  64'(bus.bht_pred_array_gwen), 64'd0);
    check("stv_wr_index", 64'(bus.bht_pred_array_index), 64'd11);
    tick(); #1;
    check("stv_resume", 64'(bus.rd_gnt), 64'd1);
    tick();
    bus.rd_req = 1'b0;

    // 4. Invalidate with a pending write, then re-invalidate at sweep idx 300
    tick();
    bus.rd_req = 1'b1; bus.rd_index = 10'd3;
    bus.wr_req = 1'b1; bus.wr_index = 10'd13; bus.wr_mask = '1; bus.wr_data = 64'hDEAD;
    #1;
    check("inv_wr_ack", 64'(bus.wr_ack), 64'd1);
    tick();
    bus.wr_req = 1'b0; bus.cp0_ifu_bht_inv = 1'b1;
    #1;
    check("inv_rd_gnt_last", 64'(bus.rd_gnt), 64'd1);
    tick();
    bus.cp0_ifu_bht_inv = 1'b0;
    #1;
    check("inv_busy", 64'(bus.bht_inv_busy), 64'd1);
    for (int i = 0; i <= 300; i++) begin
      if (i != 0) tick();
      if (i == 300) bus.cp0_ifu_bht_inv = 1'b1;
      #1;
      check("inv_sweep_idx", 64'(bus.bht_pred_array_index), 64'(i));
      check("inv_rd_blocked", 64'(bus.rd_gnt), 64'd0);
    end
    for (int i = 0; i < 1024; i++) begin
      tick();
      bus.cp0_ifu_bht_inv = 1'b0;
      #1;
      check("reinv_sweep_idx", 64'(bus.bht_pred_array_index), 64'(i));
      check("reinv_rd_blocked", 64'(bus.rd_gnt), 64'd0);
    end
    tick();
    bus.rd_req = 1'b0;
    #1;
    check("inv_busy_done", 64'(bus.bht_inv_busy), 64'd0);
    check("inv_wr_dropped", 64'(bus.bht_pred_array_cen_b), 64'd1);
    do_read(10'd13, INIT_VAL, "rd13");

    // 5. Two updates to idx 9 while reads hold the array
    tick();
    bus.rd_req = 1'b1; bus.rd_index = 10'd2;
    bus.wr_req = 1'b1; bus.wr_index = 10'd9; bus.wr_mask = 64'h3; bus.wr_data = 64'h3;
    #1;
    check("m_first_ack", 64'(bus.wr_ack), 64'd1);
    tick();
    bus.wr_mask = 64'hC; bus.wr_data = 64'hC;
    #1;
`ifdef BHT_PRE_CTRL_WR_MERGE_EN
    check("m_merge_ack", 64'(bus.wr_ack), 64'd1);
    tick();
    bus.wr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) tick();
      #1;
      if (!bus.bht_pred_array_gwen) begin found = 1'b1; break; end
    end
    check("m_write_seen", 64'(found), 64'd1);
    check("m_bwen", bus.bht_pred_bwen, 64'hFFFF_FFFF_FFFF_FFF0);
    check("m_din",  bus.bht_pred_array_din, 64'hF);
    tick();
    bus.rd_req = 1'b0;
    #1;
    check("m_single_write", 64'(bus.bht_pred_array_cen_b), 64'd1);
`else
    check("nm_second_wait", 64'(bus.wr_ack), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (!bus.bht_pred_array_gwen) begin found = 1'b1; break; end
      check("nm_wait_ack", 64'(bus.wr_ack), 64'd0);
    end
    check("nm_first_write", 64'(found), 64'd1);
    check("nm_first_bwen", bus.bht_pred_bwen, 64'hFFFF_FFFF_FFFF_FFFC);
    check("nm_ack_on_drain", 64'(bus.wr_ack), 64'd1);
    tick();
    bus.wr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) tick();
      #1;
      if (!bus.bht_pred_array_gwen) begin found = 1'b1; break; end
    end
    check("nm_second_write", 64'(found), 64'd1);
    check("nm_second_bwen", bus.bht_pred_bwen, 64'hFFFF_FFFF_FFFF_FFF3);
    check("nm_second_din",  bus.bht_pred_array_din, 64'hC);
    tick();
    bus.rd_req = 1'b0;
`endif
    do_read(10'd9, 64'h5555_5555_5555_555F, "rd9");

    // 6. No requests: array stays deselected and clock gated
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("idle_cen_b",  64'(bus.bht_pred_array_cen_b), 64'd1);
      check("idle_clk_en", 64'(bus.bht_pre_array_clk_en), 64'd0);
      check("idle_rd_vld", 64'(bus.rd_data_vld), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
